// File: rtl/fp_align_stage.sv
// Exponent-alignment stage of the single-precision FP adder.
// Restores the hidden bits and orders the operands by magnitude. The smaller
// significand is shifted right a few positions per cycle, with guard, round
// and sticky bits kept. The aligned pair is then held on a valid/ready
// handshake until the downstream stage takes it.
module fp_align_stage #(
    parameter int SHIFT_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        signA,
    input  logic        signB,
    input  logic [7:0]  exponentA,
    input  logic [7:0]  exponentB,
    input  logic [22:0] mantissaA,
    input  logic [22:0] mantissaB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign_l,
    output logic        out_sign_s,
    output logic [7:0]  out_exp,
    output logic [26:0] out_mant_l,
    output logic [26:0] out_mant_s,
    output logic        out_swap,
    output logic        out_special
);

    localparam logic [4:0] STEP      = 5'(SHIFT_PER_CYCLE);
    localparam logic [4:0] MAX_SHIFT = 5'd27;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg;
    logic [4:0]  rem_reg;

    logic        hid_a, hid_b;
    logic [7:0]  eff_a, eff_b;
    logic [26:0] sig_a, sig_b;
    logic        a_ge_b;
    logic [7:0]  exp_l, exp_s, diff;
    logic [4:0]  dc;
    logic        special;

    logic [4:0]  step_n;
    logic [26:0] shifted, lost_mask, shift_next;

    // Unpack both operands, pick the larger magnitude and clamp the shift distance
    always_comb begin
        hid_a   = (exponentA != 8'd0);
        hid_b   = (exponentB != 8'd0);
        eff_a   = hid_a ? exponentA : 8'd1;
        eff_b   = hid_b ? exponentB : 8'd1;
        sig_a   = {hid_a, mantissaA, 3'b000};
        sig_b   = {hid_b, mantissaB, 3'b000};
        // Ties go to A so that equal magnitudes never report a swap
        a_ge_b  = {eff_a, sig_a} >= {eff_b, sig_b};
        exp_l   = a_ge_b ? eff_a : eff_b;
        exp_s   = a_ge_b ? eff_b : eff_a;
        diff    = exp_l - exp_s;
        // Beyond 27 positions every significand bit lands in the sticky bit
        dc      = (diff > 8'd27) ? MAX_SHIFT : diff[4:0];
        special = (exponentA == 8'hFF) || (exponentB == 8'hFF);
    end

    // One partial right shift of the smaller significand, folding lost bits into sticky
    always_comb begin
        step_n     = (rem_reg < STEP) ? rem_reg : STEP;
        shifted    = out_mant_s >> step_n;
        lost_mask  = ~(27'h7FF_FFFF << step_n);
        shift_next = {shifted[26:1], shifted[0] | (|(out_mant_s & lost_mask))};
    end

    // Control FSM and result registers; the outputs double as the working registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rem_reg     <= 5'd0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_sign_l  <= 1'b0;
            out_sign_s  <= 1'b0;
            out_exp     <= 8'd0;
            out_mant_l  <= 27'd0;
            out_mant_s  <= 27'd0;
            out_swap    <= 1'b0;
            out_special <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        out_sign_l  <= a_ge_b ? signA : signB;
                        out_sign_s  <= a_ge_b ? signB : signA;
                        out_mant_l  <= a_ge_b ? sig_a : sig_b;
                        out_mant_s  <= a_ge_b ? sig_b : sig_a;
                        out_swap    <= ~a_ge_b;
                        out_special <= special;
                        out_exp     <= special ? 8'hFF : exp_l;
                        rem_reg     <= dc;
                        in_ready    <= 1'b0;
                        if (special || (dc == 5'd0)) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (rem_reg == MAX_SHIFT) begin
                        // Full-width shift collapses to sticky in a single cycle
                        out_mant_s <= {26'd0, |out_mant_s};
                        rem_reg    <= 5'd0;
                        state_reg  <= DONE;
                        out_valid  <= 1'b1;
                    end else begin
                        out_mant_s <= shift_next;
                        rem_reg    <= rem_reg - step_n;
                        if (rem_reg == step_n) begin
                            state_reg <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
